// File: rtl/detect_window_ctrl_pkg.sv
// Shared definitions for the detect window controller: FSM state encoding and
// the timestamp value reported for channels that never fired.
package detect_window_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_REPORT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    // Wide enough for any supported TS_WIDTH; users slice off the low bits.
    localparam int unsigned MAX_TS_WIDTH = 64;
    localparam logic [MAX_TS_WIDTH-1:0] MISS_TS = '1;

endpackage

// File: rtl/detect_capture_slot.sv
// One channel's capture state: a first-hit flag and the timestamp latched with it.
// Later hits are ignored until the slot is cleared.
module detect_capture_slot #(
    parameter int unsigned TS_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                capture,
    input  logic [TS_WIDTH-1:0] ts_in,
    output logic                captured,
    output logic [TS_WIDTH-1:0] cap_ts
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            captured <= 1'b0;
            cap_ts   <= '0;
        end else if (clear) begin
            captured <= 1'b0;
            cap_ts   <= '0;
        end else if (capture && !captured) begin
            captured <= 1'b1;
            cap_ts   <= ts_in;
        end
    end

endmodule

// File: rtl/detect_window_ctrl.sv
// Arms on the first detect, timestamps each channel's first hit within a window,
// then reports one record per channel in order and waits out a dead time.
module detect_window_ctrl
    import detect_window_ctrl_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned TS_WIDTH = 16,
    parameter int unsigned WINDOW   = 1000,
    parameter int unsigned HOLDOFF  = 50,
    localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NCH-1:0]      detect,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [TS_WIDTH-1:0] out_ts,
    output logic                out_miss,
    output logic                done,
    output logic                busy
);

    localparam logic [TS_WIDTH-1:0] TS_LAST = TS_WIDTH'(WINDOW - 1);
    localparam logic [TS_WIDTH-1:0] HO_LAST = TS_WIDTH'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [CH_W-1:0]     CH_LAST = CH_W'(NCH - 1);

    state_t              state, state_nxt;
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] hold_cnt;
    logic [CH_W-1:0]     rec_idx;
    logic [NCH-1:0]      captured;
    logic [NCH-1:0]      cap_now;
    logic [NCH-1:0]      cap_after;
    logic [TS_WIDTH-1:0] cap_ts [NCH];
    logic                arm;
    logic                window_end;
    logic                accept;
    logic                last_accept;

    // The arming cycle itself is a capture cycle at ts=0 and may also be the last one.
    assign arm         = (state == ST_IDLE) && enable && (detect != '0);
    assign cap_now     = (arm || state == ST_CAPTURE) ? (detect & ~captured) : '0;
    assign cap_after   = captured | cap_now;
    assign window_end  = (ts == TS_LAST) || (&cap_after);
    assign accept      = (state == ST_REPORT) && out_ready;
    assign last_accept = accept && (rec_idx == CH_LAST);

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        detect_capture_slot #(
            .TS_WIDTH (TS_WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .clear    (last_accept),
            .capture  (cap_now[i]),
            .ts_in    (ts),
            .captured (captured[i]),
            .cap_ts   (cap_ts[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (arm) begin
                    state_nxt = window_end ? ST_REPORT : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (window_end) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (last_accept) begin
                    state_nxt = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt == HO_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts       <= '0;
            hold_cnt <= '0;
            rec_idx  <= '0;
            done     <= 1'b0;
        end else begin
            done     <= last_accept;
            ts       <= (state_nxt == ST_CAPTURE) ? ts + TS_WIDTH'(1) : '0;
            hold_cnt <= (state == ST_HOLDOFF) ? hold_cnt + TS_WIDTH'(1) : '0;
            if (accept) begin
                rec_idx <= last_accept ? '0 : rec_idx + CH_W'(1);
            end
        end
    end

    assign out_valid = (state == ST_REPORT);
    assign busy      = (state != ST_IDLE);
    assign out_ch    = rec_idx;

    always_comb begin
        out_ts   = '0;
        out_miss = 1'b0;
        if (out_valid) begin
            if (captured[rec_idx]) begin
                out_ts = cap_ts[rec_idx];
            end else begin
                out_ts   = MISS_TS[TS_WIDTH-1:0];
                out_miss = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_detect_window_ctrl.sv
// Randomized and directed bench for detect_window_ctrl with a reference model
// and a scoreboard monitor that checks every accepted record and done pulse.
module tb_detect_window_ctrl;

    localparam int unsigned NCH      = 4;
    localparam int unsigned TS_WIDTH = 16;
    localparam int unsigned WINDOW   = 1000;
    localparam int unsigned HOLDOFF  = 50;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic [NCH-1:0]      detect;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_ch;
    logic [TS_WIDTH-1:0] out_ts;
    logic                out_miss;
    logic                done;
    logic                busy;

    always #5 clk = ~clk;

    detect_window_ctrl #(
        .NCH      (NCH),
        .TS_WIDTH (TS_WIDTH),
        .WINDOW   (WINDOW),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .detect    (detect),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_ts    (out_ts),
        .out_miss  (out_miss),
        .done      (done),
        .busy      (busy)
    );

    typedef struct packed {
        logic [1:0]          ch;
        logic [TS_WIDTH-1:0] ts;
        logic                miss;
    } rec_t;

    rec_t           exp_q[$];
    logic [NCH-1:0] sched[$];
    int             total = 0;
    int             bad = 0;
    bit             done_due = 1'b0;
    rec_t           mon_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks the done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                done_due = 1'b0;
            end else begin
                if (done || done_due) check("done_pulse", 32'(done), 32'(done_due));
                done_due = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_record", 32'd1, 32'd0);
                    end else begin
                        mon_r = exp_q.pop_front();
                        check("rec_ch", 32'(out_ch), 32'(mon_r.ch));
                        check("rec_ts", 32'(out_ts), 32'(mon_r.ts));
                        check("rec_miss", 32'(out_miss), 32'(mon_r.miss));
                        if (mon_r.ch == 2'(NCH - 1)) done_due = 1'b1;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        detect = '0;
        enable = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_out_ts", 32'(out_ts), 32'd0);
        check("rst_out_miss", 32'(out_miss), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ready_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1, 3 never ready.
    task automatic run_session(input int ready_mode, input int abort_k);
        logic [NCH-1:0] cap;
        int             cts[NCH];
        int             e;
        int             first_valid;
        int             done_k;
        int             hb;
        logic [NCH-1:0] d;
        logic [3:0]     pat;
        rec_t           r;

        pat = 4'b1001;
        if (busy) begin
            check("idle_at_start", 32'(busy), 32'd0);
            do_reset();
        end

        // Reference: first hit per channel, window closes when all hit or at WINDOW-1.
        cap = '0;
        e = WINDOW - 1;
        for (int k = 0; k < int'(WINDOW); k++) begin
            d = (k < sched.size()) ? sched[k] : '0;
            for (int c = 0; c < int'(NCH); c++) begin
                if (d[c] && !cap[c]) begin
                    cap[c] = 1'b1;
                    cts[c] = k;
                end
            end
            if (cap == '1) begin
                e = k;
                break;
            end
        end
        for (int c = 0; c < int'(NCH); c++) begin
            r.ch   = 2'(c);
            r.miss = !cap[c];
            r.ts   = cap[c] ? TS_WIDTH'(cts[c]) : {TS_WIDTH{1'b1}};
            exp_q.push_back(r);
        end

        first_valid = -1;
        done_k = -1;
        for (int k = 0; k < e + 200; k++) begin
            @(posedge clk);
            #1;
            if (k < sched.size()) detect = sched[k];
            else if (k > e) detect = NCH'($urandom);
            else detect = '0;
            enable = (k == 0) ? 1'b1 : 1'($urandom);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom);
                2: out_ready = pat[k % 4];
                default: out_ready = 1'b0;
            endcase
            @(negedge clk);
            if (out_valid && first_valid < 0) first_valid = k;
            if (k == abort_k) begin
                check("abort_busy", 32'(busy), 32'd1);
                do_reset();
                return;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        if (done_k < 0) begin
            check("done_timeout", 32'd0, 32'd1);
            do_reset();
            return;
        end
        check("report_latency", 32'(first_valid), 32'(e + 1));
        if (ready_mode == 0) check("done_latency", 32'(done_k), 32'(e + 1 + NCH));

        // Dead time: detects and enable are noise here and must be ignored.
        hb = 0;
        for (int i = 1; i < int'(HOLDOFF); i++) begin
            @(posedge clk);
            #1;
            detect = NCH'($urandom);
            enable = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            if (busy && !out_valid) hb++;
        end
        check("holdoff_busy", 32'(hb), 32'(HOLDOFF - 1));
        @(posedge clk);
        #1;
        detect = '0;
        enable = 1'b0;
        @(negedge clk);
        check("holdoff_exit", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic disabled_noise();
        int nb;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            enable = 1'b0;
            detect = NCH'($urandom_range(1, 15));
            @(negedge clk);
            if (busy) nb++;
        end
        check("disabled_ignored", 32'(nb), 32'd0);
        @(posedge clk);
        #1;
        detect = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int len;
        rst = 1'b1;
        enable = 1'b0;
        detect = '0;
        out_ready = 1'b1;
        #1;
        check("init_busy", 32'(busy), 32'd0);
        check("init_out_valid", 32'(out_valid), 32'd0);
        do_reset();

        // Staggered arrivals, all ready.
        sched = '{4'b0001, 0, 0, 4'b0100, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 4'b1000};
        run_session(0, -1);
        // All channels in one cycle.
        sched = '{4'b1111};
        run_session(0, -1);
        // Single channel, window runs out.
        sched = '{4'b0010};
        run_session(0, -1);
        // Same arrivals with a stalling consumer.
        sched = '{4'b0001, 0, 0, 4'b0100, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 4'b1000};
        run_session(2, -1);
        // Hit in the last window cycle is kept, one just after it is not.
        sched.delete();
        for (int k = 0; k <= int'(WINDOW); k++) sched.push_back('0);
        sched[0] = 4'b0001;
        sched[WINDOW - 1] = 4'b1000;
        sched[WINDOW] = 4'b0100;
        run_session(0, -1);
        // Resets mid-CAPTURE and mid-REPORT.
        sched = '{4'b0001};
        run_session(0, 5);
        sched = '{4'b1111};
        run_session(3, 3);
        disabled_noise();
        sched = '{4'b0101, 0, 4'b0010};
        run_session(1, -1);

        for (int s = 0; s < 20; s++) begin
            sched.delete();
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                sched.push_back(($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0);
            end
            sched[0] = NCH'($urandom_range(1, 15));
            run_session($urandom_range(0, 2), -1);
            if (s % 7 == 3) disabled_noise();
        end

        check("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/detect_window_ctrl.md
DETECT_WINDOW_CTRL -- requirements
Module: detect_window_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of threshold-detector channels.
REQ-002 Parameter TS_WIDTH, default 16: arrival-timestamp width.
REQ-003 Parameter WINDOW, default 1000: capture window length in cycles; legal range 1 to 2^TS_WIDTH-1.
REQ-004 Parameter HOLDOFF, default 50: dead time in cycles after reporting; legal range 0 to 2^TS_WIDTH-1.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port enable, input, 1: arms the controller; sampled only in IDLE.
REQ-008 Port detect, input, NCH: one-cycle detect pulses, one bit per channel.
REQ-009 Port out_valid, output, 1: a result record is presented.
REQ-010 Port out_ready, input, 1: consumer accepts a record when high together with out_valid.
REQ-011 Port out_ch, output, clog2(NCH): channel index of the presented record.
REQ-012 Port out_ts, output, TS_WIDTH: arrival time relative to the first detect.
REQ-013 Port out_miss, output, 1: channel did not detect within the window.
REQ-014 Port done, output, 1: one-cycle pulse after the last record is accepted.
REQ-015 Port busy, output, 1: high in every state except IDLE.

Function
REQ-016 States: IDLE, CAPTURE, REPORT, HOLDOFF.
REQ-017 IDLE to CAPTURE: in a cycle with enable=1 and detect!=0.
  - ts counter loads 0.
  - Every channel whose detect bit is high in that cycle is captured with ts 0.
REQ-018 Detect pulses in IDLE with enable=0 are ignored.
REQ-019 CAPTURE: ts increments by 1 per cycle.
  - A channel's first detect is captured with the current ts value.
  - Later detects on an already-captured channel are ignored.
REQ-020 Simultaneous detects on several uncaptured channels are all captured in the same cycle with the same ts.
REQ-021 CAPTURE ends after the cycle in which all NCH channels are captured, or the cycle in which ts equals WINDOW-1, whichever comes first.
  - A detect arriving in that final cycle is still captured.
  - Next state is REPORT.
REQ-022 ts never wraps; it cannot exceed WINDOW-1.
REQ-023 REPORT presents channels in order 0 to NCH-1, one record per handshake.
  - Captured channel: out_miss=0, out_ts=captured value.
  - Uncaptured channel: out_miss=1, out_ts all ones.
REQ-024 out_ch, out_ts and out_miss are held stable while out_valid=1 and out_ready=0.
REQ-025 The record index advances only on out_valid & out_ready; back-to-back acceptance gives one record per cycle.
REQ-026 out_valid is asserted from the first REPORT cycle.
REQ-027 When the record for channel NCH-1 is accepted:
  - out_valid drops in the next cycle.
  - done pulses for exactly one cycle in that next cycle.
  - State goes to HOLDOFF.
REQ-028 HOLDOFF lasts exactly HOLDOFF cycles, ignoring detect, then returns to IDLE.
  - HOLDOFF=0 means direct return to IDLE.
REQ-029 Detect inputs are ignored in REPORT and HOLDOFF.
REQ-030 enable is not sampled outside IDLE; deasserting it mid-cycle does not abort the sequence.

Reset
REQ-031 rst high forces IDLE immediately from any state, including mid-CAPTURE and mid-REPORT, and discards partial results.
REQ-032 Reset values: out_valid=0, done=0, busy=0, out_ch=0, out_ts=0, out_miss=0, ts=0, all capture flags cleared.
REQ-033 First possible capture: the first rising clk edge after rst deasserts.

Structure
REQ-034 State encoding constants and the MISS_TS (all-ones) constant are defined in the shared project package.
REQ-035 A sub-module detect_capture_slot holds one channel's captured flag and timestamp register, instantiated NCH times; sequencing and reporting stay in detect_window_ctrl.

Verification
REQ-036 Settings for all scenarios: NCH=4, WINDOW=1000, HOLDOFF=50, out_ready=1 unless stated otherwise.
  - Detects on ch0 at t0, ch2 at t0+3, ch1 at t0+7, ch3 at t0+12 -> records (0,0,miss0), (1,7,0), (2,3,0), (3,12,0) on 4 consecutive cycles, then done pulse, then 50 HOLDOFF cycles.
  - detect=4'b1111 in one cycle -> all ts=0, REPORT entered in the next cycle.
  - Only ch1 pulses -> window expires at ts=999; ch1 ts=0; ch0, ch2, ch3 have out_miss=1 and ts=16'hFFFF.
  - out_ready toggles 1,0,0,1 -> outputs held stable during stall, no record lost or duplicated.
  - rst asserted mid-CAPTURE and mid-REPORT -> IDLE with all outputs at reset values; a detect during HOLDOFF or with enable=0 is ignored.
